// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_pkg
// Purpose  : Shared opcode constants, control-field encodings and the ID/EX
//            control bundle used by the pipelined control unit.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MDU  = 7'b0000001;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'b00000, ALU_SUB   = 5'b00001, ALU_AND    = 5'b00010,
    ALU_OR     = 5'b00011, ALU_XOR   = 5'b00100, ALU_SLL    = 5'b00101,
    ALU_SRL    = 5'b00110, ALU_SRA   = 5'b00111, ALU_SLT    = 5'b01000,
    ALU_SLTU   = 5'b01001, ALU_LUI   = 5'b01010,
    ALU_MUL    = 5'b10000, ALU_MULH  = 5'b10001, ALU_MULHSU = 5'b10010,
    ALU_MULHU  = 5'b10011, ALU_DIV   = 5'b10100, ALU_DIVU   = 5'b10101,
    ALU_REM    = 5'b10110, ALU_REMU  = 5'b10111
  } alu_ctrl_e;

  typedef enum logic [2:0] {
    IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010, IMM_U = 3'b011, IMM_J = 3'b100
  } imm_src_e;

  typedef enum logic [2:0] {
    BR_NONE = 3'b000, BR_BEQ = 3'b001, BR_BNE  = 3'b010, BR_BLT = 3'b011,
    BR_BGE  = 3'b100, BR_BLTU = 3'b101, BR_BGEU = 3'b110
  } branch_e;

  typedef enum logic [1:0] {
    JMP_NONE = 2'b00, JMP_JAL = 2'b10, JMP_JALR = 2'b11
  } jump_e;

  typedef enum logic [3:0] {
    AM_LB = 4'b0000, AM_LH = 4'b0001, AM_LW = 4'b0010, AM_LBU = 4'b0011,
    AM_LHU = 4'b0100, AM_SB = 4'b0101, AM_SH = 4'b0110, AM_SW = 4'b0111,
    AM_NONE = 4'b1000
  } addr_mode_e;

  typedef struct packed {
    alu_ctrl_e  alu_ctrl;
    logic       alu_src;
    logic       alu_src_a;
    imm_src_e   imm_src;
    logic       reg_write;
    logic [4:0] rd;
    branch_e    branch;
    jump_e      jump;
    addr_mode_e addr_mode;
    logic       result_src;
    logic       wd3_src;
    logic       valid;
    logic       illegal;
  } ctrl_bundle_t;

  // Empty EX slot: no memory access, everything else cleared.
  function automatic ctrl_bundle_t ctrl_bubble();
    ctrl_bundle_t b;
    b = '0;
    b.addr_mode = AM_NONE;
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_decode
// Purpose  : Purely combinational RV32I(+M) decoder producing the control
//            bundle for one instruction and a flag marking divide-class ops.
// Ports    : instr   - 32-bit instruction word
//            bundle  - decoded control bundle (valid = 1)
//            is_div  - DIV/DIVU/REM/REMU (only when M_EXT = 1)
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int M_EXT = 1
) (
  input  logic [31:0]  instr,
  output ctrl_bundle_t bundle,
  output logic         is_div
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       illegal;
  logic       unused_bits;
  ctrl_bundle_t b;

  assign opcode      = instr[6:0];
  assign funct3      = instr[14:12];
  assign funct7      = instr[31:25];
  // Register-source fields are not needed for control decode.
  assign unused_bits = ^instr[24:15];

  always_comb begin
    b         = ctrl_bubble();
    b.valid   = 1'b1;
    b.rd      = instr[11:7];
    illegal   = 1'b0;
    is_div    = 1'b0;

    case (opcode)
      OP_R: begin
        b.reg_write = 1'b1;
        case (funct7)
          F7_BASE: begin
            case (funct3)
              3'b000:  b.alu_ctrl = ALU_ADD;
              3'b001:  b.alu_ctrl = ALU_SLL;
              3'b010:  b.alu_ctrl = ALU_SLT;
              3'b011:  b.alu_ctrl = ALU_SLTU;
              3'b100:  b.alu_ctrl = ALU_XOR;
              3'b101:  b.alu_ctrl = ALU_SRL;
              3'b110:  b.alu_ctrl = ALU_OR;
              default: b.alu_ctrl = ALU_AND;
            endcase
          end
          F7_ALT: begin
            if (funct3 == 3'b000)      b.alu_ctrl = ALU_SUB;
            else if (funct3 == 3'b101) b.alu_ctrl = ALU_SRA;
            else                       illegal    = 1'b1;
          end
          F7_MDU: begin
            if (M_EXT != 0) begin
              // MDU codes are 10 followed by funct3.
              b.alu_ctrl = alu_ctrl_e'({2'b10, funct3});
              is_div     = funct3[2];
            end else begin
              illegal = 1'b1;
            end
          end
          default: illegal = 1'b1;
        endcase
      end
      OP_IMM: begin
        b.reg_write = 1'b1;
        b.alu_src   = 1'b1;
        b.imm_src   = IMM_I;
        case (funct3)
          3'b000: b.alu_ctrl = ALU_ADD;
          3'b010: b.alu_ctrl = ALU_SLT;
          3'b011: b.alu_ctrl = ALU_SLTU;
          3'b100: b.alu_ctrl = ALU_XOR;
          3'b110: b.alu_ctrl = ALU_OR;
          3'b111: b.alu_ctrl = ALU_AND;
          3'b001: begin
            if (funct7 == F7_BASE) b.alu_ctrl = ALU_SLL;
            else                   illegal    = 1'b1;
          end
          default: begin
            if (funct7 == F7_BASE)     b.alu_ctrl = ALU_SRL;
            else if (funct7 == F7_ALT) b.alu_ctrl = ALU_SRA;
            else                       illegal    = 1'b1;
          end
        endcase
      end
      OP_LOAD: begin
        b.reg_write  = 1'b1;
        b.alu_src    = 1'b1;
        b.result_src = 1'b1;
        case (funct3)
          3'b000:  b.addr_mode = AM_LB;
          3'b001:  b.addr_mode = AM_LH;
          3'b010:  b.addr_mode = AM_LW;
          3'b100:  b.addr_mode = AM_LBU;
          3'b101:  b.addr_mode = AM_LHU;
          default: illegal     = 1'b1;
        endcase
      end
      OP_STORE: begin
        b.alu_src = 1'b1;
        b.imm_src = IMM_S;
        case (funct3)
          3'b000:  b.addr_mode = AM_SB;
          3'b001:  b.addr_mode = AM_SH;
          3'b010:  b.addr_mode = AM_SW;
          default: illegal     = 1'b1;
        endcase
      end
      OP_BRANCH: begin
        b.alu_ctrl = ALU_SUB;
        b.imm_src  = IMM_B;
        case (funct3)
          3'b000:  b.branch = BR_BEQ;
          3'b001:  b.branch = BR_BNE;
          3'b100:  b.branch = BR_BLT;
          3'b101:  b.branch = BR_BGE;
          3'b110:  b.branch = BR_BLTU;
          3'b111:  b.branch = BR_BGEU;
          default: illegal  = 1'b1;
        endcase
      end
      OP_LUI: begin
        b.reg_write = 1'b1;
        b.alu_src   = 1'b1;
        b.imm_src   = IMM_U;
        b.alu_ctrl  = ALU_LUI;
      end
      OP_AUIPC: begin
        b.reg_write = 1'b1;
        b.alu_src   = 1'b1;
        b.alu_src_a = 1'b1;
        b.imm_src   = IMM_U;
      end
      OP_JAL: begin
        b.reg_write = 1'b1;
        b.alu_src   = 1'b1;
        b.alu_src_a = 1'b1;
        b.imm_src   = IMM_J;
        b.wd3_src   = 1'b1;
        b.jump      = JMP_JAL;
      end
      OP_JALR: begin
        b.reg_write = 1'b1;
        b.alu_src   = 1'b1;
        b.imm_src   = IMM_I;
        b.wd3_src   = 1'b1;
        b.jump      = JMP_JALR;
      end
      // ECALL/EBREAK and FENCE retire with no architectural side effect here.
      OP_SYSTEM, OP_FENCE: b.rd = 5'd0;
      default: illegal = 1'b1;
    endcase

    if (illegal) begin
      b         = ctrl_bubble();
      b.valid   = 1'b1;
      b.illegal = 1'b1;
      is_div    = 1'b0;
    end

    if (b.rd == 5'd0) b.reg_write = 1'b0;
  end

  assign bundle = b;

endmodule
`default_nettype wire

// File: rtl/pipelined_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_control_unit
// Purpose  : Decodes the ID instruction and registers the control bundle into
//            the ID/EX boundary with stall/flush support; holds EX while a
//            multi-cycle divide is in flight.
// Ports    : clk, rst (sync, active-high); instr/instr_valid from ID;
//            stall (insert bubble), flush (squash EX and divide);
//            stall_req (hold IF/ID during divide); *E registered controls.
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_control_unit
  import ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int M_EXT      = 1,
  parameter int DIV_CYCLES = 34
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] instr,
  input  logic                  instr_valid,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  stall_req,
  output logic [4:0]            ALUctrlE,
  output logic                  ALUsrcE,
  output logic                  ALUsrcAE,
  output logic [2:0]            ImmSrcE,
  output logic                  RegWriteE,
  output logic [4:0]            rdE,
  output logic [2:0]            branchE,
  output logic [1:0]            JumpE,
  output logic [3:0]            AddrModeE,
  output logic                  ResultSrcE,
  output logic                  WD3SrcE,
  output logic                  validE,
  output logic                  illegalE
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_BUSY   = 1'b1;
  localparam logic [7:0] DIV_LOAD = 8'(DIV_CYCLES - 1);

  ctrl_bundle_t dec_bundle;
  logic         dec_is_div;
  ctrl_bundle_t e_q, e_d;
  logic [0:0]   state_q, state_d;
  logic [7:0]   cnt_q, cnt_d;

  ctrl_decode #(.M_EXT(M_EXT)) u_decode (
    .instr  (instr[31:0]),
    .bundle (dec_bundle),
    .is_div (dec_is_div)
  );

  if (DATA_WIDTH > 32) begin : g_unused_hi
    logic unused_hi;
    assign unused_hi = ^instr[DATA_WIDTH-1:32];
  end

  // State register and ID/EX register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      e_q     <= ctrl_bubble();
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      e_q     <= e_d;
    end
  end

  // Next state, divide counter and EX bundle: flush > divide hold > stall > load.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    e_d     = e_q;
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = 8'd0;
      e_d     = ctrl_bubble();
    end else if (state_q == S_BUSY) begin
      cnt_d = cnt_q - 8'd1;
      if (cnt_q == 8'd1) state_d = S_IDLE;
    end else if (stall || !instr_valid) begin
      e_d = ctrl_bubble();
    end else begin
      e_d = dec_bundle;
      if (dec_is_div) begin
        state_d = S_BUSY;
        cnt_d   = DIV_LOAD;
      end
    end
  end

  // FSM output.
  always_comb begin
    stall_req = (state_q == S_BUSY);
  end

  assign ALUctrlE   = e_q.alu_ctrl;
  assign ALUsrcE    = e_q.alu_src;
  assign ALUsrcAE   = e_q.alu_src_a;
  assign ImmSrcE    = e_q.imm_src;
  assign RegWriteE  = e_q.reg_write;
  assign rdE        = e_q.rd;
  assign branchE    = e_q.branch;
  assign JumpE      = e_q.jump;
  assign AddrModeE  = e_q.addr_mode;
  assign ResultSrcE = e_q.result_src;
  assign WD3SrcE    = e_q.wd3_src;
  assign validE     = e_q.valid;
  assign illegalE   = e_q.illegal;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_control_unit
// Purpose  : Directed self-checking bench. Two instances share stimulus:
//            dut (M_EXT = 1) and dut_nm (M_EXT = 0), both DIV_CYCLES = 4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipelined_control_unit;

  localparam logic [31:0] I_SUB  = 32'h40B50533; // sub  a0, a0, a1
  localparam logic [31:0] I_ADDZ = 32'h00100013; // addi x0, x0, 1
  localparam logic [31:0] I_JALR = 32'h000280E7; // jalr x1, 0(x5)
  localparam logic [31:0] I_MUL  = 32'h02B50533; // mul  a0, a0, a1
  localparam logic [31:0] I_LW   = 32'h0005A503; // lw   a0, 0(a1)
  localparam logic [31:0] I_BEQ  = 32'h00000063; // beq  x0, x0, 0
  localparam logic [31:0] I_DIV  = 32'h02C5C533; // div  a0, a1, a2
  localparam logic [31:0] I_ADDI = 32'h00500593; // addi a1, x0, 5

  logic        clk = 1'b0;
  logic        rst, instr_valid, stall, flush;
  logic [31:0] instr;

  logic       stall_req, ALUsrcE, ALUsrcAE, RegWriteE, ResultSrcE, WD3SrcE, validE, illegalE;
  logic [4:0] ALUctrlE, rdE;
  logic [2:0] ImmSrcE, branchE;
  logic [1:0] JumpE;
  logic [3:0] AddrModeE;

  logic       n_stall_req, n_ALUsrcE, n_ALUsrcAE, n_RegWriteE, n_ResultSrcE, n_WD3SrcE, n_validE, n_illegalE;
  logic [4:0] n_ALUctrlE, n_rdE;
  logic [2:0] n_ImmSrcE, n_branchE;
  logic [1:0] n_JumpE;
  logic [3:0] n_AddrModeE;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pipelined_control_unit #(.DATA_WIDTH(32), .M_EXT(1), .DIV_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .stall(stall), .flush(flush), .stall_req(stall_req),
    .ALUctrlE(ALUctrlE), .ALUsrcE(ALUsrcE), .ALUsrcAE(ALUsrcAE), .ImmSrcE(ImmSrcE),
    .RegWriteE(RegWriteE), .rdE(rdE), .branchE(branchE), .JumpE(JumpE),
    .AddrModeE(AddrModeE), .ResultSrcE(ResultSrcE), .WD3SrcE(WD3SrcE),
    .validE(validE), .illegalE(illegalE)
  );

  pipelined_control_unit #(.DATA_WIDTH(32), .M_EXT(0), .DIV_CYCLES(4)) dut_nm (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .stall(stall), .flush(flush), .stall_req(n_stall_req),
    .ALUctrlE(n_ALUctrlE), .ALUsrcE(n_ALUsrcE), .ALUsrcAE(n_ALUsrcAE), .ImmSrcE(n_ImmSrcE),
    .RegWriteE(n_RegWriteE), .rdE(n_rdE), .branchE(n_branchE), .JumpE(n_JumpE),
    .AddrModeE(n_AddrModeE), .ResultSrcE(n_ResultSrcE), .WD3SrcE(n_WD3SrcE),
    .validE(n_validE), .illegalE(n_illegalE)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle before sampling outputs / changing inputs.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; instr = 32'h0; instr_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    step();
    step();
    check_eq("rst_validE",    32'(validE),    32'd0);
    check_eq("rst_AddrModeE", 32'(AddrModeE), 32'h8);
    check_eq("rst_stall_req", 32'(stall_req), 32'd0);
    check_eq("rst_RegWriteE", 32'(RegWriteE), 32'd0);
    check_eq("rst_ALUctrlE",  32'(ALUctrlE),  32'd0);

    rst = 1'b0; instr = I_SUB; instr_valid = 1'b1;
    step();
    check_eq("sub_ALUctrlE",  32'(ALUctrlE),  32'h01);
    check_eq("sub_RegWriteE", 32'(RegWriteE), 32'd1);
    check_eq("sub_rdE",       32'(rdE),       32'd10);
    check_eq("sub_validE",    32'(validE),    32'd1);
    check_eq("sub_illegalE",  32'(illegalE),  32'd0);

    instr = I_ADDZ;
    step();
    check_eq("addx0_RegWriteE", 32'(RegWriteE), 32'd0);
    check_eq("addx0_validE",    32'(validE),    32'd1);
    check_eq("addx0_ALUsrcE",   32'(ALUsrcE),   32'd1);

    instr = I_JALR;
    step();
    check_eq("jalr_JumpE",     32'(JumpE),     32'h3);
    check_eq("jalr_WD3SrcE",   32'(WD3SrcE),   32'd1);
    check_eq("jalr_RegWriteE", 32'(RegWriteE), 32'd1);

    instr = I_MUL;
    step();
    check_eq("mul_ALUctrlE",     32'(ALUctrlE),     32'h10);
    check_eq("mul_RegWriteE",    32'(RegWriteE),    32'd1);
    check_eq("mul_stall_req",    32'(stall_req),    32'd0);
    check_eq("nm_mul_illegalE",  32'(n_illegalE),   32'd1);
    check_eq("nm_mul_validE",    32'(n_validE),     32'd1);
    check_eq("nm_mul_RegWriteE", 32'(n_RegWriteE),  32'd0);
    check_eq("nm_mul_AddrModeE", 32'(n_AddrModeE),  32'h8);

    instr = I_BEQ;
    step();
    check_eq("beq_branchE",   32'(branchE),   32'h1);
    check_eq("beq_ImmSrcE",   32'(ImmSrcE),   32'h2);
    check_eq("beq_RegWriteE", 32'(RegWriteE), 32'd0);

    instr = I_LW; stall = 1'b1;
    step();
    check_eq("stall_validE",    32'(validE),    32'd0);
    check_eq("stall_AddrModeE", 32'(AddrModeE), 32'h8);
    stall = 1'b0;
    step();
    check_eq("lw_AddrModeE",  32'(AddrModeE),  32'h2);
    check_eq("lw_ResultSrcE", 32'(ResultSrcE), 32'd1);
    check_eq("lw_validE",     32'(validE),     32'd1);

    instr_valid = 1'b0;
    step();
    check_eq("novalid_validE",    32'(validE),    32'd0);
    check_eq("novalid_AddrModeE", 32'(AddrModeE), 32'h8);

    // Divide: stall_req high for 3 cycles, EX held for 4.
    instr = I_DIV; instr_valid = 1'b1;
    step();
    check_eq("div_ALUctrlE",    32'(ALUctrlE),    32'h14);
    check_eq("div_stall_req_0", 32'(stall_req),   32'd1);
    check_eq("nm_div_illegalE", 32'(n_illegalE),  32'd1);
    check_eq("nm_div_stall_req", 32'(n_stall_req), 32'd0);
    instr = I_ADDI;
    for (int k = 1; k <= 3; k++) begin
      step();
      check_eq($sformatf("div_hold_ALUctrlE_%0d", k), 32'(ALUctrlE), 32'h14);
      check_eq($sformatf("div_stall_req_%0d", k), 32'(stall_req), (k < 3) ? 32'd1 : 32'd0);
    end
    step();
    check_eq("after_div_ALUctrlE", 32'(ALUctrlE), 32'h00);
    check_eq("after_div_rdE",      32'(rdE),      32'd11);

    // Flush on the second busy cycle.
    instr = I_DIV;
    step();
    instr = I_ADDI;
    step();
    check_eq("fl_pre_stall_req", 32'(stall_req), 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_eq("fl_validE",    32'(validE),    32'd0);
    check_eq("fl_stall_req", 32'(stall_req), 32'd0);
    check_eq("fl_AddrModeE", 32'(AddrModeE), 32'h8);
    step();
    check_eq("fl_next_rdE",    32'(rdE),    32'd11);
    check_eq("fl_next_validE", 32'(validE), 32'd1);

    // Stall during busy is ignored.
    instr = I_DIV;
    step();
    instr = I_ADDI; stall = 1'b1;
    step();
    stall = 1'b0;
    check_eq("bst_ALUctrlE",  32'(ALUctrlE),  32'h14);
    check_eq("bst_validE",    32'(validE),    32'd1);
    check_eq("bst_stall_req", 32'(stall_req), 32'd1);

    // Reset during busy.
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("brst_validE",    32'(validE),    32'd0);
    check_eq("brst_stall_req", 32'(stall_req), 32'd0);
    check_eq("brst_ALUctrlE",  32'(ALUctrlE),  32'd0);
    check_eq("brst_AddrModeE", 32'(AddrModeE), 32'h8);
    step();
    check_eq("brst_next_rdE", 32'(rdE), 32'd11);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
